// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi BER monitor.
package viterbi_pkg;

    // Monitor run state
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Width of the consecutive-mismatch burst tracker
    localparam int unsigned BurstW = 8;

    // Add inc to v, holding at maxv instead of wrapping
    function automatic logic [63:0] sat_add(input logic [63:0] v, input logic inc,
                                            input logic [63:0] maxv);
        if (inc && (v != maxv)) begin
            return v + 64'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/viterbi_bit_fifo.sv
// 1-bit synchronous FIFO holding reference bits until the decoder catches up.
// Simultaneous push and pop are allowed, including when full.
module viterbi_bit_fifo #(
    parameter int unsigned DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Extra MSB on each pointer distinguishes full from empty
    logic [AW:0]       wr_q, rd_q;
    logic [DEPTH-1:0]  mem_q;

    // Pointer update; flush empties the FIFO without touching storage
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PtrOne;
            if (pop)  rd_q <= rd_q + PtrOne;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/viterbi_ber_monitor.sv
// Bit-error-rate monitor downstream of the Viterbi decoder. Pairs buffered
// encoder input bits with decoded bits in order and counts mismatches.
// Optional feature macro: BER_BURST_EN enables the max-burst tracker;
// when undefined max_burst_o is tied to zero.
module viterbi_ber_monitor
    import viterbi_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned WIN   = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     clear_i,
    input  logic                     ref_i,
    input  logic                     ref_valid_i,
    input  logic                     dec_i,
    input  logic                     dec_valid_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [CNT_W-1:0]         bit_ct_o,
    output logic [CNT_W-1:0]         err_ct_o,
    output logic                     win_done_o,
    output logic [$clog2(WIN+1)-1:0] win_err_o,
    output logic                     ovf_o,
    output logic                     udf_o,
    output logic [7:0]               max_burst_o
);

    localparam int unsigned WinErrW = $clog2(WIN + 1);
    localparam int unsigned WinCntW = $clog2(WIN);
    localparam logic [63:0] CntMax  = 64'({CNT_W{1'b1}});
    localparam logic [WinCntW-1:0] WinLast = WinCntW'(WIN - 1);

    state_e               state_q;
    logic                 flush, active, push, pop, mismatch;
    logic                 head, full, empty;
    logic                 err_q, win_done_q, ovf_q, udf_q;
    logic [CNT_W-1:0]     bit_ct_q, err_ct_q;
    logic [WinCntW-1:0]   win_cnt_q;
    logic [WinErrW-1:0]   win_acc_q, win_err_q;

    // Start flushes only when stop is not also asserted; stop wins
    assign flush    = start_i & ~stop_i;
    // Traffic in the flush cycle is discarded
    assign active   = (state_q == StRun) & ~flush;
    assign pop      = active & dec_valid_i & ~empty;
    assign push     = active & ref_valid_i & (~full | pop);
    assign mismatch = pop & (head ^ dec_i);

    viterbi_bit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (ref_i),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Run-state FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (stop_i) begin
            state_q <= StIdle;
        end else if (start_i) begin
            state_q <= StRun;
        end
    end

    // Compare result, totals, window accounting and sticky diagnostics
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            win_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            bit_ct_q   <= '0;
            err_ct_q   <= '0;
            win_cnt_q  <= '0;
            win_acc_q  <= '0;
            win_err_q  <= '0;
        end else begin
            err_q      <= mismatch;
            win_done_q <= 1'b0;
            if (clear_i) begin
                ovf_q     <= 1'b0;
                udf_q     <= 1'b0;
                bit_ct_q  <= '0;
                err_ct_q  <= '0;
                win_cnt_q <= '0;
                win_acc_q <= '0;
                win_err_q <= '0;
            end else begin
                if (active && ref_valid_i && full && !pop) ovf_q <= 1'b1;
                if (active && dec_valid_i && empty)        udf_q <= 1'b1;
                if (flush) begin
                    win_cnt_q <= '0;
                    win_acc_q <= '0;
                end else if (pop) begin
                    bit_ct_q <= CNT_W'(sat_add(64'(bit_ct_q), 1'b1, CntMax));
                    err_ct_q <= CNT_W'(sat_add(64'(err_ct_q), mismatch, CntMax));
                    if (win_cnt_q == WinLast) begin
                        win_done_q <= 1'b1;
                        win_err_q  <= win_acc_q + WinErrW'(mismatch);
                        win_cnt_q  <= '0;
                        win_acc_q  <= '0;
                    end else begin
                        win_cnt_q <= win_cnt_q + WinCntW'(1);
                        win_acc_q <= win_acc_q + WinErrW'(mismatch);
                    end
                end
            end
        end
    end

`ifdef BER_BURST_EN
    localparam logic [63:0] BurstMax = 64'({BurstW{1'b1}});
    logic [BurstW-1:0] burst_q, burst_max_q, burst_inc;

    assign burst_inc = BurstW'(sat_add(64'(burst_q), 1'b1, BurstMax));

    // Current mismatch run and its high-water mark; a matching compare ends a run
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            burst_q     <= '0;
            burst_max_q <= '0;
        end else if (pop) begin
            if (mismatch) begin
                burst_q <= burst_inc;
                if (burst_inc > burst_max_q) burst_max_q <= burst_inc;
            end else begin
                burst_q <= '0;
            end
        end
    end

    assign max_burst_o = burst_max_q;
`else
    assign max_burst_o = '0;
`endif

    assign busy_o     = (state_q == StRun);
    assign err_o      = err_q;
    assign bit_ct_o   = bit_ct_q;
    assign err_ct_o   = err_ct_q;
    assign win_done_o = win_done_q;
    assign win_err_o  = win_err_q;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Self-checking bench for viterbi_ber_monitor: a queue-based reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_viterbi_ber_monitor;

    localparam int DEPTH = 64;
    localparam int CNT_W = 10;
    localparam int WIN   = 256;
    localparam int WW    = $clog2(WIN + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk, rst;
    logic             start_i, stop_i, clear_i, ref_i, ref_valid_i, dec_i, dec_valid_i;
    logic             busy_o, err_o, win_done_o, ovf_o, udf_o;
    logic [CNT_W-1:0] bit_ct_o, err_ct_o;
    logic [WW-1:0]    win_err_o;
    logic [7:0]       max_burst_o;

    viterbi_ber_monitor #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .WIN  (WIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .clear_i    (clear_i),
        .ref_i      (ref_i),
        .ref_valid_i(ref_valid_i),
        .dec_i      (dec_i),
        .dec_valid_i(dec_valid_i),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .bit_ct_o   (bit_ct_o),
        .err_ct_o   (err_ct_o),
        .win_done_o (win_done_o),
        .win_err_o  (win_err_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o),
        .max_burst_o(max_burst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int wd_seen, wd_at_bit, err_seen;
    logic rb [300];

    // Reference model state
    bit mq[$];
    int m_bit, m_err, m_wcnt, m_wacc, m_werr, m_burst, m_max;
    bit m_run, m_erro, m_wd, m_ovf, m_udf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the monitor's rules at each rising edge
    always @(posedge clk) begin : model
        bit startf, active, pop, push, mm, head;
        int sz;
        if (rst) begin
            mq.delete();
            m_bit = 0; m_err = 0; m_wcnt = 0; m_wacc = 0; m_werr = 0;
            m_burst = 0; m_max = 0;
            m_run = 0; m_erro = 0; m_wd = 0; m_ovf = 0; m_udf = 0;
        end else begin
            startf = start_i && !stop_i;
            active = m_run && !startf;
            sz     = mq.size();
            pop    = active && dec_valid_i && (sz > 0);
            head   = pop ? mq[0] : 1'b0;
            push   = active && ref_valid_i && ((sz < DEPTH) || pop);
            mm     = pop && (head != dec_i);
            m_erro = mm;
            m_wd   = 0;
            if (startf) mq.delete();
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(ref_i);
            if (clear_i) begin
                m_bit = 0; m_err = 0; m_wcnt = 0; m_wacc = 0; m_werr = 0;
                m_ovf = 0; m_udf = 0; m_burst = 0; m_max = 0;
            end else begin
                if (active && ref_valid_i && sz == DEPTH && !pop) m_ovf = 1;
                if (active && dec_valid_i && sz == 0) m_udf = 1;
                if (startf) begin
                    m_wcnt = 0; m_wacc = 0;
                end else if (pop) begin
                    if (m_bit < CMAX) m_bit++;
                    if (mm && m_err < CMAX) m_err++;
                    m_wcnt++;
                    m_wacc += int'(mm);
                    if (m_wcnt == WIN) begin
                        m_wd = 1; m_werr = m_wacc; m_wcnt = 0; m_wacc = 0;
                    end
                    if (mm) begin
                        if (m_burst < 255) m_burst++;
                        if (m_burst > m_max) m_max = m_burst;
                    end else begin
                        m_burst = 0;
                    end
                end
            end
            if (stop_i) m_run = 0;
            else if (start_i) m_run = 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_o", 32'(busy_o), 32'(m_run));
            chk("err_o", 32'(err_o), 32'(m_erro));
            chk("bit_ct_o", 32'(bit_ct_o), m_bit);
            chk("err_ct_o", 32'(err_ct_o), m_err);
            chk("win_done_o", 32'(win_done_o), 32'(m_wd));
            chk("win_err_o", 32'(win_err_o), m_werr);
            chk("ovf_o", 32'(ovf_o), 32'(m_ovf));
            chk("udf_o", 32'(udf_o), 32'(m_udf));
`ifdef BER_BURST_EN
            chk("max_burst_o", 32'(max_burst_o), m_max);
`else
            chk("max_burst_o", 32'(max_burst_o), 32'd0);
`endif
            if (win_done_o === 1'b1) begin
                wd_seen++;
                if (wd_seen == 1) wd_at_bit = int'(bit_ct_o);
            end
            if (err_o === 1'b1) err_seen++;
        end
    end

    // Apply one cycle of inputs; returns at the following falling edge
    task automatic drive(input logic st, input logic sp, input logic cl, input logic rv,
                         input logic r, input logic dv, input logic d);
        start_i = st; stop_i = sp; clear_i = cl;
        ref_valid_i = rv; ref_i = r; dec_valid_i = dv; dec_i = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // n reference bits with the decoder lagging by lag cycles; flips compares f0..f2
    task automatic run_stream(input int n, input int lag, input int f0, input int f1,
                              input int f2);
        for (int i = 0; i < 300; i++) rb[i] = 1'($urandom_range(0, 1));
        for (int t = 0; t < n + lag; t++) begin
            int  idx;
            logic rv, r, dv, d;
            idx = t - lag;
            rv  = (t < n);
            r   = rv ? rb[t] : 1'b0;
            dv  = (idx >= 0) && (idx < n);
            d   = dv ? (rb[idx] ^ ((idx == f0) || (idx == f1) || (idx == f2))) : 1'b0;
            drive(0, 0, 0, rv, r, dv, d);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        int exp_burst;
        rst = 1'b1;
        start_i = 0; stop_i = 0; clear_i = 0;
        ref_i = 0; ref_valid_i = 0; dec_i = 0; dec_valid_i = 0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", 32'(busy_o), 0);
        chk("reset bit_ct", 32'(bit_ct_o), 0);
        chk("reset win_err", 32'(win_err_o), 0);
        rst = 1'b0;

        // Matched stream with 20-cycle decoder lag
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("busy after start", 32'(busy_o), 1);
        wd_seen = 0;
        run_stream(300, 20, -1, -1, -1);
        idle(2);
        chk("clean bit_ct", 32'(bit_ct_o), 300);
        chk("clean err_ct", 32'(err_ct_o), 0);
        chk("clean win_done count", wd_seen, 1);
        chk("clean win_err", 32'(win_err_o), 0);

        // Three flipped compares, two of them back to back
        drive(0, 0, 1, 0, 0, 0, 0);
        wd_seen = 0; err_seen = 0;
        run_stream(300, 20, 9, 10, 99);
        idle(2);
        chk("flip err_ct", 32'(err_ct_o), 3);
        chk("flip err_o pulses", err_seen, 3);
        chk("flip win_err", 32'(win_err_o), 3);
`ifdef BER_BURST_EN
        exp_burst = 2;
`else
        exp_burst = 0;
`endif
        chk("flip max_burst", 32'(max_burst_o), exp_burst);

        // Overflow, push+pop when full, drain exactly DEPTH bits, then underflow
        drive(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 65; i++) drive(0, 0, 0, 1, 1'($urandom_range(0, 1)), 0, 0);
        chk("ovf set", 32'(ovf_o), 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
        chk("push+pop full ovf", 32'(ovf_o), 0);
        chk("push+pop full bit_ct", 32'(bit_ct_o), 1);
        for (int i = 0; i < 64; i++) drive(0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
        chk("drain udf", 32'(udf_o), 0);
        chk("drain bit_ct", 32'(bit_ct_o), 65);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("empty pop udf", 32'(udf_o), 1);
        chk("empty pop bit_ct", 32'(bit_ct_o), 65);

        // clear_i coincident with a mismatching compare
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 0);
        chk("clear err_ct", 32'(err_ct_o), 0);
        chk("clear bit_ct", 32'(bit_ct_o), 0);
        chk("clear busy", 32'(busy_o), 1);
        chk("clear err_o", 32'(err_o), 1);

        // Random traffic long enough to saturate the counters
        for (int i = 0; i < 2500; i++)
            drive(0, 0, 0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        chk("saturated bit_ct", 32'(bit_ct_o), CMAX);

        // Random traffic with occasional start/stop/clear
        for (int i = 0; i < 1500; i++)
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 1),
                  ($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

        // Reset mid-window, then a full window must be counted afresh
        pulse_rst();
        drive(1, 0, 0, 0, 0, 0, 0);
        run_stream(100, 1, -1, -1, -1);
        chk("pre-rst bit_ct", 32'(bit_ct_o), 100);
        pulse_rst();
        chk("rst busy", 32'(busy_o), 0);
        chk("rst bit_ct", 32'(bit_ct_o), 0);
        chk("rst ovf/udf", 32'({ovf_o, udf_o}), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        wd_seen = 0; wd_at_bit = -1;
        run_stream(300, 1, -1, -1, -1);
        idle(2);
        chk("restart win_done count", wd_seen, 1);
        chk("restart win_done at", wd_at_bit, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_monitor.md
# viterbi_ber_monitor

Bit-error-rate monitor sitting directly downstream of the Viterbi decoder in the tx/rx chain. Buffers the raw information bits presented to the convolutional encoder, pairs each with the corresponding decoded bit in arrival order, and counts mismatches. Provides running totals, per-window error counts and overflow/underflow diagnostics for error-injection benches and on-chip link checks.

## Interface

Parameters:
- DEPTH, 64: reference FIFO depth in bits (power of two, ≥ max encoder-to-decoder latency in bits).
- CNT_W, 32: width of total bit and error counters.
- WIN, 256: decoded bits per measurement window (≥ 2).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  IDLE→RUN; flushes FIFO, resets window counter.
- stop_i  in  1  RUN→IDLE.
- clear_i  in  1  zeroes counters, sticky flags and burst tracker; FIFO unaffected.
- ref_i  in  1  encoder input bit.
- ref_valid_i  in  1  push ref_i into FIFO.
- dec_i  in  1  decoder output bit.
- dec_valid_i  in  1  dec_i valid; pop FIFO head and compare.
- busy_o  out  1  high in RUN.
- err_o  out  1  one-cycle pulse: previous compare mismatched.
- bit_ct_o  out  CNT_W  total compared bits.
- err_ct_o  out  CNT_W  total mismatches.
- win_done_o  out  1  one-cycle pulse at window end.
- win_err_o  out  $clog2(WIN+1)  errors in last completed window.
- ovf_o  out  1  sticky: push attempted while FIFO full.
- udf_o  out  1  sticky: dec_valid_i while FIFO empty.
- max_burst_o  out  8  longest run of consecutive mismatches (see Configuration).

## Operation

- States: IDLE (reset state), RUN. IDLE→RUN on start_i; RUN→IDLE on stop_i; start_i and stop_i together: stop wins, stay/enter IDLE, no flush.
- In IDLE, ref_valid_i and dec_valid_i are ignored; FIFO holds contents.
- RUN push: ref_valid_i with FIFO not full writes ref_i. Full and no pop in same cycle: bit dropped, ovf_o set. Full with simultaneous pop: push accepted.
- RUN pop: dec_valid_i with FIFO non-empty pops head, compares with dec_i. Empty: no compare, udf_o set, no counter change; a same-cycle push is not bypassed to the compare.
- Compare result registered: err_o = head ^ dec_i, one cycle later; bit_ct_o +1, err_ct_o +mismatch on same edge.
- Counters saturate at all-ones; no wrap.
- Window: internal count of compares; on WIN-th compare, next cycle win_done_o pulses and win_err_o loads window error total (including that compare); window counters restart at 0.
- clear_i takes priority over same-cycle counter increments; window counter also zeroed; state unchanged.
- Reset: state IDLE, FIFO empty, all outputs 0.

## Timing

- Push-to-pop: minimum one cycle (bit written at edge N poppable at N+1).
- dec_valid_i at edge N → err_o, bit_ct_o, err_ct_o updated at edge N+1.
- win_done_o asserted exactly one cycle per WIN compares; win_err_o stable until next window ends.
- start_i flush effective same edge; pushes in that cycle are discarded.
- rst mid-window or mid-burst: all state discarded, outputs 0 on next edge.

## Configuration

- BER_BURST_EN defined: tracks current consecutive-mismatch run (saturating 8-bit), max_burst_o = largest run since reset/clear_i, updated same edge as err_o.
- Undefined: burst logic removed; max_burst_o tied to 0.

## Structure

- Package viterbi_pkg: state enum (IDLE, RUN), burst-width constant, shared saturating-increment function.
- One sub-module: viterbi_bit_fifo (1-bit synchronous FIFO, DEPTH, full/empty, simultaneous push/pop).

## Test plan

- Reset, start_i, 300 identical ref/dec bits, decoder lag 20 cycles → err_ct_o=0, bit_ct_o=300, one win_done_o with win_err_o=0.
- Flip dec_i on compares 10, 11, 100 → err_ct_o=3, err_o pulses one cycle after each; max_burst_o=2 with BER_BURST_EN, 0 without.
- 65 pushes without pops, DEPTH=64 → ovf_o=1, FIFO count 64; push+pop when full → no ovf change.
- dec_valid_i on empty FIFO → udf_o=1, bit_ct_o unchanged.
- clear_i coincident with a mismatch compare → err_ct_o=0, bit_ct_o=0, flags cleared, busy_o still 1.
- rst asserted mid-window after 100 compares → all outputs 0, state IDLE; restart yields win_done_o only after another 256 compares.
